alu_shift_seq: RTL and testbench

- Multi-pass shift sequencer in front of the integer ALU.
- The ALU's shift path handles only shift amounts 0..7. This block executes full 5-bit SLL/SRL (shamt 0..31) by chaining passes of at most STEP_MAX bits through the ALU.
- Sits beside decode. It takes the ALU for the duration of the operation and asserts stall to the pipeline.

---
 rtl/alu_shift_seq_pkg.sv | 24 ++
 rtl/alu_shift_seq_step_calc.sv | 19 +
 rtl/alu_shift_seq.sv | 121 ++++++++++++
 tb/tb_alu_shift_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_shift_seq_pkg.sv
// Shared constants for the multi-pass shift sequencer: ALU opcode/funct
// codes, default per-pass shift limit, FSM state encoding, direction codes.
package alu_shift_seq_pkg;

   // R-type opcode and shift funct codes understood by the integer ALU
   localparam logic [5:0] INST_R    = 6'b000000;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;

   // Largest shift amount the ALU shift path accepts in one pass
   localparam int SEQ_STEP_MAX = 7;

   // Request direction encoding
   localparam logic SEQ_DIR_SLL = 1'b0;
   localparam logic SEQ_DIR_SRL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAPT = 2'd2,
      DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_shift_seq_step_calc.sv
// Per-pass step calculator: clamps the remaining shift to the ALU limit and
// flags the final pass (the pass that leaves nothing remaining).
module shift_step_calc #(
   parameter int STEP_MAX = 7
) (
   input  logic [4:0] rem,
   output logic [4:0] step,
   output logic       last
);

   localparam logic [4:0] STEP_LIM = 5'(STEP_MAX);

   // rem == 0 still yields one pass with step 0, flagged last
   always_comb begin
      last = (rem <= STEP_LIM);
      step = last ? rem : STEP_LIM;
   end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-pass shift sequencer: executes SLL/SRL with 5-bit shift amounts by
// chaining passes of at most STEP_MAX bits through the ALU, stalling the
// pipeline while it owns the ALU.
module alu_shift_seq
   import alu_shift_seq_pkg::*;
#(
   parameter int W        = 32,
   parameter int STEP_MAX = SEQ_STEP_MAX
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_dir,
   input  logic [W-1:0] req_data,
   input  logic [4:0]   req_shamt,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         stall,
   output logic         alu_own_fwd,
   output logic         alu_own,
   output logic [5:0]   alu_opcode_fwd,
   output logic [5:0]   alu_opcode,
   output logic [5:0]   alu_funct,
   output logic [4:0]   alu_shamt,
   output logic [W-1:0] alu_rrt,
   input  logic [W-1:0] alu_rslt
);

   seq_state_t   state;
   logic [W-1:0] data_q;
   logic [4:0]   rem;
   logic         first;
   logic [4:0]   step;
   logic         last;
   logic         accept;

   shift_step_calc #(.STEP_MAX(STEP_MAX)) u_step (
      .rem  (rem),
      .step (step),
      .last (last)
   );

   assign accept = req_valid && req_ready;

   // Forward ownership leads alu_own by a cycle so the ALU's registered
   // operand select is already R-type on the first RUN cycle.
   always_comb begin
      alu_own_fwd    = accept || (state == RUN);
      alu_opcode_fwd = alu_own_fwd ? INST_R : 6'd0;
   end

   // Per-pass operands: first pass shifts the latched operand, later passes
   // chain the ALU's registered result from the previous pass.
   always_comb begin
      alu_shamt = 5'd0;
      alu_rrt   = '0;
      if (state == RUN) begin
         alu_shamt = step;
         alu_rrt   = first ? data_q : alu_rslt;
      end
   end

   // Sequencer FSM with registered handshake, stall and ALU-ownership outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         data_q     <= '0;
         rem        <= 5'd0;
         first      <= 1'b0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         stall      <= 1'b0;
         alu_own    <= 1'b0;
         alu_opcode <= 6'd0;
         alu_funct  <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q     <= req_data;
                  rem        <= req_shamt;
                  first      <= 1'b1;
                  alu_funct  <= (req_dir == SEQ_DIR_SRL) ? FUNCT_SRL : FUNCT_SLL;
                  req_ready  <= 1'b0;
                  stall      <= 1'b1;
                  alu_own    <= 1'b1;
                  alu_opcode <= INST_R;
                  state      <= RUN;
               end
            end
            RUN: begin
               rem   <= rem - step;
               first <= 1'b0;
               if (last) state <= CAPT;
            end
            CAPT: begin
               // Result of the final pass is in the ALU output register now
               rsp_data   <= alu_rslt;
               rsp_valid  <= 1'b1;
               alu_own    <= 1'b0;
               alu_opcode <= 6'd0;
               alu_funct  <= 6'd0;
               state      <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  stall     <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: behavioural ALU model, directed
// scenarios, mid-operation reset, and a randomized sweep of all shamt/dir.
module tb_alu_shift_seq;
   import alu_shift_seq_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_dir = 1'b0;
   logic [W-1:0] req_data = '0;
   logic [4:0]   req_shamt = 5'd0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         stall;
   logic         alu_own_fwd;
   logic         alu_own;
   logic [5:0]   alu_opcode_fwd;
   logic [5:0]   alu_opcode;
   logic [5:0]   alu_funct;
   logic [4:0]   alu_shamt;
   logic [W-1:0] alu_rrt;
   logic [W-1:0] alu_rslt = '0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_shift_seq #(.W(W), .STEP_MAX(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
      .req_data(req_data), .req_shamt(req_shamt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .stall(stall), .alu_own_fwd(alu_own_fwd), .alu_own(alu_own),
      .alu_opcode_fwd(alu_opcode_fwd), .alu_opcode(alu_opcode),
      .alu_funct(alu_funct), .alu_shamt(alu_shamt), .alu_rrt(alu_rrt),
      .alu_rslt(alu_rslt)
   );

   // ALU model: registered shift when owned, unrelated garbage otherwise
   always @(posedge clk) begin
      if (alu_own)
         alu_rslt <= (alu_funct == FUNCT_SRL) ? (alu_rrt >> alu_shamt[2:0])
                                              : (alu_rrt << alu_shamt[2:0]);
      else
         alu_rslt <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction, starting at a negedge with the DUT idle
   task automatic run_op(input logic dir, input logic [W-1:0] data, input int sh, input int hold);
      logic [W-1:0] exp_data;
      logic [W-1:0] held;
      int exp_p, cyc, stl;
      int shq[$];
      int expq[$];
      exp_data = dir ? (data >> sh) : (data << sh);
      exp_p    = (sh == 0) ? 1 : (sh + 6) / 7;
      if (sh == 0) expq.push_back(0);
      else begin
         for (int i = 0; i < sh / 7; i++) expq.push_back(7);
         if (sh % 7 != 0) expq.push_back(sh % 7);
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_dir = dir; req_data = data; req_shamt = 5'(sh); req_valid = 1'b1;
      #1 chk("own_fwd_accept", 32'(alu_own_fwd), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0; req_data = $urandom; req_shamt = 5'($urandom);
      req_dir = ~dir;
      cyc = 0; stl = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         stl += 32'(stall);
         if (alu_own && alu_own_fwd) begin
            shq.push_back(int'(alu_shamt));
            if (shq.size() == 1)
               chk("funct", 32'(alu_funct), 32'(dir ? FUNCT_SRL : FUNCT_SLL));
         end
         if (rsp_valid || cyc > 40) break;
         rsp_ready = 1'($urandom_range(0, 1));
      end
      chk("latency", 32'(cyc - 1), 32'(exp_p + 1));
      chk("pass_count", 32'(shq.size()), 32'(expq.size()));
      for (int i = 0; i < shq.size() && i < expq.size(); i++)
         chk("pass_shamt", 32'(shq[i]), 32'(expq[i]));
      chk("rsp_data", rsp_data, exp_data);
      held = rsp_data;
      rsp_ready = (hold == 0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_data = $urandom; req_shamt = 5'($urandom);
         @(negedge clk);
         stl += 32'(stall);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", rsp_data, held);
         chk("hold_ready", 32'(req_ready), 32'd0);
         if (i == hold - 1) begin
            req_valid = 1'b0; rsp_ready = 1'b1;
         end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
      chk("ready_after", 32'(req_ready), 32'd1);
      chk("stall_after", 32'(stall), 32'd0);
      chk("stall_cycles", 32'(stl), 32'(exp_p + 2 + hold));
   endtask

   initial begin
      bit seen;
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_own", 32'(alu_own), 32'd0);
      chk("rst_own_fwd", 32'(alu_own_fwd), 32'd0);
      chk("rst_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_opcode_fwd", 32'(alu_opcode_fwd), 32'd0);
      chk("rst_funct", 32'(alu_funct), 32'd0);
      chk("rst_shamt", 32'(alu_shamt), 32'd0);
      chk("rst_rrt", alu_rrt, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Directed scenarios
      run_op(1'b0, 32'h0000_0001, 31, 0);
      run_op(1'b1, 32'hF000_000F, 8, 0);
      run_op(1'b0, 32'hDEAD_BEEF, 0, 0);
      run_op(1'b1, $urandom, 13, 4);
      run_op(1'b0, $urandom, 20, 0);   // back-to-back after the hold case

      // Reset during the third RUN cycle of a 31-bit shift
      req_dir = 1'b0; req_data = $urandom; req_shamt = 5'd31; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_own", 32'(alu_own), 32'd0);
      chk("abort_own_fwd", 32'(alu_own_fwd), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_shamt", 32'(alu_shamt), 32'd0);
      chk("abort_rrt", alu_rrt, 32'd0);
      chk("abort_opcode", 32'(alu_opcode), 32'd0);
      chk("abort_funct", 32'(alu_funct), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("abort_no_rsp", 32'(seen), 32'd0);
      run_op(1'b0, 32'h0000_0001, 31, 0);

      // Sweep every shift amount in both directions with random operands
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 32; s++)
            run_op(1'(d), $urandom, s, int'($urandom_range(0, 2)));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
